// File: rtl/wave_frame_norm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wave_frame_norm_if : ADC capture / normalised-waveform handshake bundle
// rev 1.0
// ---------------------------------------------------------------------------
interface wave_frame_norm_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        adc_data;
    logic              adc_valid;
    logic [ADDR_W-1:0] tmpl_addr;
    logic [7:0]        wave_in;
    logic [7:0]        dwave_in;
    logic              wave_valid;
    logic              frame_done;
    logic              busy;
    logic              span_low;

    modport master (
        output start, adc_data, adc_valid,
        input  tmpl_addr, wave_in, dwave_in, wave_valid, frame_done, busy, span_low
    );

    modport slave (
        input  start, adc_data, adc_valid,
        output tmpl_addr, wave_in, dwave_in, wave_valid, frame_done, busy, span_low
    );
endinterface
`default_nettype wire

// File: rtl/wave_frame_norm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wave_frame_norm : captures one ADC frame, min/max shift-normalises it and
// replays samples plus centred first differences.  rev 1.0
// ---------------------------------------------------------------------------
module wave_frame_norm #(
    parameter int FRAME_LEN  = 256,
    parameter int ADDR_W     = 8,
    parameter int DIFF_SHIFT = 0,
    parameter int MIN_SPAN   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    wave_frame_norm_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_CALC    = 3'd2;
    localparam logic [2:0] S_PLAY    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    logic [2:0]        state, state_nxt;
    logic [7:0]        mem [FRAME_LEN];
    logic [ADDR_W-1:0] wr_ptr, rd_idx, rd_addr;
    logic [7:0]        rd_data, min_val, max_val, span, offs, norm, norm_prev;
    logic [3:0]        lz;
    logic              seen;
    logic [2:0]        gain_k, gain_k_nxt;
    logic              drain, cap_wr;
    logic signed [8:0] diff, diff_sh;
    logic signed [9:0] centred;
    logic [7:0]        dwave_nxt, wave_r, dwave_r;
    logic              valid_r, span_low_r, busy_c, done_c;

    assign cap_wr = (state == S_CAPTURE) && bus.adc_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start) state_nxt = S_CAPTURE;
            S_CAPTURE: if (cap_wr && wr_ptr == LAST_IDX) state_nxt = S_CALC;
            S_CALC:    state_nxt = S_PLAY;
            S_PLAY:    if (drain) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != S_IDLE);
        done_c = (state == S_DONE);
    end

    // ---------------- frame buffer ----------------
    // Read runs one sample ahead so RAM latency is hidden behind tmpl_addr.
    assign rd_addr = (state == S_CALC) ? '0 : rd_idx + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (cap_wr) mem[wr_ptr] <= bus.adc_data;
        rd_data <= mem[rd_addr];
    end

    // ---------------- gain / datapath ----------------
    assign span = max_val - min_val;

    always_comb begin
        lz   = 4'd0;
        seen = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            if (span[b])    seen = 1'b1;
            else if (!seen) lz   = lz + 4'd1;
        end
        gain_k_nxt = (lz == 4'd8) ? 3'd0 : lz[2:0];
    end

    always_comb begin
        offs    = rd_data - min_val;
        norm    = offs << gain_k;
        diff    = (rd_idx == '0) ? 9'sd0
                                 : $signed({1'b0, norm}) - $signed({1'b0, norm_prev});
        diff_sh = diff >>> DIFF_SHIFT;
        centred = $signed({diff_sh[8], diff_sh}) + 10'sd128;
        if (centred < 10'sd0)        dwave_nxt = 8'd0;
        else if (centred > 10'sd255) dwave_nxt = 8'd255;
        else                         dwave_nxt = centred[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_idx     <= '0;
            min_val    <= 8'd255;
            max_val    <= 8'd0;
            gain_k     <= 3'd0;
            drain      <= 1'b0;
            norm_prev  <= 8'd0;
            wave_r     <= 8'd0;
            dwave_r    <= 8'd128;
            valid_r    <= 1'b0;
            span_low_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    wr_ptr  <= '0;
                    min_val <= 8'd255;
                    max_val <= 8'd0;
                end
                S_CAPTURE: if (bus.adc_valid) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (bus.adc_data < min_val) min_val <= bus.adc_data;
                    if (bus.adc_data > max_val) max_val <= bus.adc_data;
                end
                S_CALC: begin
                    gain_k     <= gain_k_nxt;
                    span_low_r <= (int'(span) < MIN_SPAN);
                    rd_idx     <= '0;
                    drain      <= 1'b0;
                end
                S_PLAY: if (!drain) begin
                    norm_prev <= norm;
                    wave_r    <= norm;
                    dwave_r   <= dwave_nxt;
                    valid_r   <= 1'b1;
                    if (rd_idx == LAST_IDX) drain  <= 1'b1;
                    else                    rd_idx <= rd_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.tmpl_addr  = rd_idx;
    assign bus.wave_in    = wave_r;
    assign bus.dwave_in   = dwave_r;
    assign bus.wave_valid = valid_r;
    assign bus.frame_done = done_c;
    assign bus.busy       = busy_c;
    assign bus.span_low   = span_low_r;
endmodule
`default_nettype wire

// File: tb/tb_wave_frame_norm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wave_frame_norm : directed + randomised frames against a frame-level model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_wave_frame_norm;
    localparam int N = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wave_frame_norm_if #(.ADDR_W(8)) bus0 ();
    wave_frame_norm_if #(.ADDR_W(8)) bus2 ();

    assign bus2.start     = bus0.start;
    assign bus2.adc_data  = bus0.adc_data;
    assign bus2.adc_valid = bus0.adc_valid;

    wave_frame_norm #(.FRAME_LEN(N), .ADDR_W(8), .DIFF_SHIFT(0), .MIN_SPAN(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    wave_frame_norm #(.FRAME_LEN(N), .ADDR_W(8), .DIFF_SHIFT(2), .MIN_SPAN(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    int checks = 0;
    int failures = 0;
    int samp [N];
    int exp_norm [N];
    int exp_d0 [N];
    int exp_d2 [N];
    int exp_low;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    // Frame-level reference: gain is the largest doubling that keeps span in 8 bits.
    task automatic build_model();
        int mn, mx, sp, k, d;
        mn = 255; mx = 0;
        for (int i = 0; i < N; i++) begin
            if (samp[i] < mn) mn = samp[i];
            if (samp[i] > mx) mx = samp[i];
        end
        sp = mx - mn;
        k = 0;
        if (sp != 0)
            while (k < 7 && sp * (2 ** (k + 1)) <= 255) k++;
        for (int i = 0; i < N; i++) begin
            exp_norm[i] = (samp[i] - mn) * (2 ** k);
            d = (i == 0) ? 0 : exp_norm[i] - exp_norm[i-1];
            exp_d0[i] = clamp8(128 + d);
            exp_d2[i] = clamp8(128 + (d >>> 2));
        end
        exp_low = (sp < 16) ? 1 : 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus0.wave_valid, 0);
        check({tag, "_busy"},  bus0.busy, 0);
        check({tag, "_done"},  bus0.frame_done, 0);
        check({tag, "_dwave"}, bus0.dwave_in, 128);
        check({tag, "_dwave2"}, bus2.dwave_in, 128);
        check({tag, "_wave"},  bus0.wave_in, 0);
        check({tag, "_addr"},  bus0.tmpl_addr, 0);
        check({tag, "_low"},   bus0.span_low, 0);
    endtask

    task automatic run_frame(input bit toggle, input bit restart_mid, input bit reset_mid);
        logic [7:0] a_prev;
        build_model();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (toggle) begin
                bus0.adc_valid = 1'b0;
                bus0.adc_data  = 8'($urandom_range(0, 255));
                tick();
            end
            bus0.adc_valid = 1'b1;
            bus0.adc_data  = 8'(samp[i]);
            tick();
        end
        bus0.adc_valid = 1'b0;
        check("calc_busy", bus0.busy, 1);
        check("calc_valid", bus0.wave_valid, 0);
        tick();
        check("play0_valid", bus0.wave_valid, 0);
        check("play0_addr", bus0.tmpl_addr, 0);
        for (int i = 0; i < N; i++) begin
            a_prev = bus0.tmpl_addr;
            bus0.adc_valid = 1'($urandom_range(0, 1));
            bus0.adc_data  = 8'($urandom_range(0, 255));
            bus0.start     = (restart_mid && i == 100) ? 1'b1 : 1'b0;
            if (reset_mid && i == 60) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("async_rst");
                bus0.adc_valid = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                check_reset_outputs("post_rst");
                return;
            end
            tick();
            check("wave_valid", bus0.wave_valid, 1);
            check("wave_in", bus0.wave_in, exp_norm[i]);
            check("dwave_s0", bus0.dwave_in, exp_d0[i]);
            check("dwave_s2", bus2.dwave_in, exp_d2[i]);
            check("addr_align", {24'd0, a_prev}, i);
        end
        bus0.start = 1'b0;
        bus0.adc_valid = 1'b0;
        tick();
        check("done_pulse", bus0.frame_done, 1);
        check("done_valid", bus0.wave_valid, 0);
        check("done_busy", bus0.busy, 1);
        tick();
        check("after_done", bus0.frame_done, 0);
        check("idle_busy", bus0.busy, 0);
        check("span_low", bus0.span_low, exp_low);
        check("span_low2", bus2.span_low, exp_low);
        if (restart_mid) begin
            tick();
            tick();
            check("no_restart", bus0.busy, 0);
        end
    endtask

    task automatic fill_random();
        int base, width;
        base  = $urandom_range(0, 250);
        width = $urandom_range(0, 255 - base);
        for (int i = 0; i < N; i++) samp[i] = base + $urandom_range(0, width);
    endtask

    initial begin
        bus0.start = 1'b0;
        bus0.adc_valid = 1'b0;
        bus0.adc_data = 8'd0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) samp[i] = i;
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) samp[i] = 64 + (i % 32);
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) samp[i] = 100;
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) samp[i] = (i >= 100 && i < 200) ? 200 : 0;
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) samp[i] = $urandom_range(0, 255);
        run_frame(1'b1, 1'b0, 1'b0);

        fill_random();
        run_frame(1'b0, 1'b1, 1'b0);

        fill_random();
        run_frame(1'b0, 1'b0, 1'b1);

        fill_random();
        run_frame(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
